// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the two-port memory bus arbiter.
package mem_bus_arbiter_pkg;

   localparam int REG_BUS   = 32;
   localparam int NUM_PORTS = 2;
   localparam int PORT_D    = 0;
   localparam int PORT_I    = 1;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_D = 2'd1,
      ARB_BUSY_I = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic               we;
      logic [REG_BUS-1:0] addr;
      logic [3:0]         sel;
      logic [REG_BUS-1:0] data;
   } bus_cmd_t;

endpackage

// File: rtl/mem_arb_port.sv
// Per-port result buffer: holds a completed access until the stage consumes it.
module mem_arb_port
   import mem_bus_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               hold,
   input  logic               capture,
   input  logic [REG_BUS-1:0] capture_data,
   output logic               vld,
   output logic [REG_BUS-1:0] data
);

   // A flush discards the buffered result; the arbiter never captures during a flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld  <= 1'b0;
         data <= '0;
      end else if (flush) begin
         vld <= 1'b0;
      end else if (capture) begin
         vld  <= 1'b1;
         data <= capture_data;
      end else if (vld && !hold) begin
         vld <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises instruction-fetch and data accesses onto one variable-latency bus,
// with data priority, result buffering, flush discard and an ack watchdog.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               i_ce_i,
   input  logic [REG_BUS-1:0] i_addr_i,
   input  logic               i_hold_i,
   output logic [REG_BUS-1:0] i_data_o,
   output logic               i_stallreq_o,
   input  logic               d_ce_i,
   input  logic               d_we_i,
   input  logic [REG_BUS-1:0] d_addr_i,
   input  logic [3:0]         d_sel_i,
   input  logic [REG_BUS-1:0] d_data_i,
   input  logic               d_hold_i,
   output logic [REG_BUS-1:0] d_data_o,
   output logic               d_stallreq_o,
   output logic               bus_req_o,
   output logic               bus_we_o,
   output logic [REG_BUS-1:0] bus_addr_o,
   output logic [3:0]         bus_sel_o,
   output logic [REG_BUS-1:0] bus_data_o,
   input  logic [REG_BUS-1:0] bus_data_i,
   input  logic               bus_ack_i,
   output logic               bus_err_o
);

   localparam bit              WDOG_ON  = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t         state_reg, state_next;
   bus_cmd_t           cmd_reg, cmd_next;
   logic               req_reg, req_next;
   logic               err_reg, err_next;
   logic               discard_reg, discard_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               timeout;

   logic [NUM_PORTS-1:0] vld;
   logic [NUM_PORTS-1:0] hold;
   logic [NUM_PORTS-1:0] capture;
   logic [REG_BUS-1:0]   capture_data;
   logic [REG_BUS-1:0]   result [NUM_PORTS];

   assign hold[PORT_D] = d_hold_i;
   assign hold[PORT_I] = i_hold_i;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         mem_arb_port u_port (
            .clk          (clk),
            .rst          (rst),
            .flush        (flush),
            .hold         (hold[gi]),
            .capture      (capture[gi]),
            .capture_data (capture_data),
            .vld          (vld[gi]),
            .data         (result[gi])
         );
      end
   endgenerate

   assign timeout = WDOG_ON && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ARB_IDLE;
         cmd_reg     <= '0;
         req_reg     <= 1'b0;
         err_reg     <= 1'b0;
         discard_reg <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         cmd_reg     <= cmd_next;
         req_reg     <= req_next;
         err_reg     <= err_next;
         discard_reg <= discard_next;
         cnt_reg     <= cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cmd_next     = cmd_reg;
      req_next     = req_reg;
      err_next     = 1'b0;
      discard_next = discard_reg;
      cnt_next     = cnt_reg;
      capture      = '0;
      capture_data = '0;
      case (state_reg)
         ARB_IDLE: begin
            cnt_next     = '0;
            discard_next = 1'b0;
            // Data wins ties: it belongs to the older instruction in the pipe.
            if (!flush) begin
               if (d_ce_i && !vld[PORT_D]) begin
                  state_next = ARB_BUSY_D;
                  req_next   = 1'b1;
                  cmd_next   = '{we: d_we_i, addr: d_addr_i, sel: d_sel_i, data: d_data_i};
               end else if (i_ce_i && !vld[PORT_I]) begin
                  state_next = ARB_BUSY_I;
                  req_next   = 1'b1;
                  cmd_next   = '{we: 1'b0, addr: i_addr_i, sel: 4'b1111, data: '0};
               end
            end
         end
         ARB_BUSY_D, ARB_BUSY_I: begin
            if (bus_ack_i || timeout) begin
               state_next   = ARB_IDLE;
               req_next     = 1'b0;
               cnt_next     = '0;
               discard_next = 1'b0;
               err_next     = !bus_ack_i;
               if (!discard_reg && !flush) begin
                  capture[PORT_D] = (state_reg == ARB_BUSY_D);
                  capture[PORT_I] = (state_reg == ARB_BUSY_I);
                  capture_data    = (bus_ack_i && !cmd_reg.we) ? bus_data_i : '0;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
               if (flush) begin
                  discard_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = ARB_IDLE;
            req_next   = 1'b0;
         end
      endcase
   end

   assign bus_req_o    = req_reg;
   assign bus_we_o     = cmd_reg.we;
   assign bus_addr_o   = cmd_reg.addr;
   assign bus_sel_o    = cmd_reg.sel;
   assign bus_data_o   = cmd_reg.data;
   assign bus_err_o    = err_reg;
   assign d_data_o     = result[PORT_D];
   assign i_data_o     = result[PORT_I];
   assign d_stallreq_o = d_ce_i & ~vld[PORT_D];
   assign i_stallreq_o = i_ce_i & ~vld[PORT_I];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised and directed checks of mem_bus_arbiter against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        i_ce_i = 1'b0, i_hold_i = 1'b0;
   logic [31:0] i_addr_i = '0;
   logic [31:0] i_data_o;
   logic        i_stallreq_o;
   logic        d_ce_i = 1'b0, d_we_i = 1'b0, d_hold_i = 1'b0;
   logic [31:0] d_addr_i = '0, d_data_i = '0;
   logic [3:0]  d_sel_i = '0;
   logic [31:0] d_data_o;
   logic        d_stallreq_o;
   logic        bus_req_o, bus_we_o, bus_err_o;
   logic [31:0] bus_addr_o, bus_data_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_data_i = '0;
   logic        bus_ack_i = 1'b0;

   int tests = 0;
   int fails = 0;

   mem_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .i_ce_i(i_ce_i), .i_addr_i(i_addr_i), .i_hold_i(i_hold_i),
      .i_data_o(i_data_o), .i_stallreq_o(i_stallreq_o),
      .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_sel_i(d_sel_i),
      .d_data_i(d_data_i), .d_hold_i(d_hold_i),
      .d_data_o(d_data_o), .d_stallreq_o(d_stallreq_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_sel_o(bus_sel_o), .bus_data_o(bus_data_o),
      .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o)
   );

   always #5 clk = ~clk;

   // Model: who owns the bus (0 none, 1 data, 2 fetch), how long it has waited,
   // what each port has buffered, and the command latched at grant time.
   int          owner;
   int          age;
   bit          discard;
   bit          mv [2];
   logic [31:0] mbuf [2];
   bit          merr;
   logic        mwe;
   logic [31:0] maddr, mwdata;
   logic [3:0]  msel;

   // Snapshot of DUT outputs taken each cycle, for the directed checks.
   logic        o_dstall, o_istall, o_req, o_err, o_we;
   logic [31:0] o_addr, o_wdata, o_ddata, o_idata;
   logic [3:0]  o_sel;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner = 0; age = 0; discard = 0; merr = 0;
      mv[0] = 0; mv[1] = 0; mbuf[0] = '0; mbuf[1] = '0;
      mwe = 0; maddr = '0; mwdata = '0; msel = '0;
   endtask

   task automatic compare();
      check("bus_req", {31'b0, bus_req_o}, {31'b0, owner != 0});
      check("bus_err", {31'b0, bus_err_o}, {31'b0, merr});
      check("d_stallreq", {31'b0, d_stallreq_o}, {31'b0, d_ce_i && !mv[0]});
      check("i_stallreq", {31'b0, i_stallreq_o}, {31'b0, i_ce_i && !mv[1]});
      if (owner != 0) begin
         check("bus_we", {31'b0, bus_we_o}, {31'b0, mwe});
         check("bus_addr", bus_addr_o, maddr);
         check("bus_sel", {28'b0, bus_sel_o}, {28'b0, msel});
         check("bus_data", bus_data_o, mwdata);
      end
      if (mv[0]) check("d_data", d_data_o, mbuf[0]);
      if (mv[1]) check("i_data", i_data_o, mbuf[1]);
   endtask

   task automatic model_step();
      bit          nv [2];
      logic [31:0] nb [2];
      bit          hold_in [2];
      bit          nerr;
      int          p;
      hold_in[0] = d_hold_i;
      hold_in[1] = i_hold_i;
      nerr = 0;
      for (int k = 0; k < 2; k++) begin
         nb[k] = mbuf[k];
         nv[k] = flush ? 1'b0 : (mv[k] && hold_in[k]);
      end
      if (owner != 0) begin
         if (bus_ack_i || age + 1 == TO) begin
            if (!discard && !flush) begin
               p = (owner == 1) ? 0 : 1;
               nv[p] = 1;
               nb[p] = (bus_ack_i && !(owner == 1 && mwe)) ? bus_data_i : 32'h0;
            end
            nerr = !bus_ack_i;
            owner = 0; age = 0; discard = 0;
         end else begin
            age++;
            if (flush) discard = 1;
         end
      end else if (!flush) begin
         if (d_ce_i && !mv[0]) begin
            owner = 1; age = 0;
            mwe = d_we_i; maddr = d_addr_i; msel = d_sel_i; mwdata = d_data_i;
         end else if (i_ce_i && !mv[1]) begin
            owner = 2; age = 0;
            mwe = 0; maddr = i_addr_i; msel = 4'hf; mwdata = '0;
         end
      end
      mv = nv;
      mbuf = nb;
      merr = nerr;
   endtask

   // One clock cycle: inputs already set at the falling edge.
   task automatic tick();
      #1;
      compare();
      o_dstall = d_stallreq_o; o_istall = i_stallreq_o;
      o_req = bus_req_o; o_err = bus_err_o; o_we = bus_we_o;
      o_addr = bus_addr_o; o_wdata = bus_data_o; o_sel = bus_sel_o;
      o_ddata = d_data_o; o_idata = i_data_o;
      model_step();
      @(negedge clk);
   endtask

   task automatic quiet();
      d_ce_i = 0; d_we_i = 0; d_hold_i = 0; i_ce_i = 0; i_hold_i = 0;
      flush = 0; bus_ack_i = 0;
   endtask

   task automatic drain();
      bit done;
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         quiet();
         bus_ack_i = (owner != 0);
         bus_data_i = $urandom;
         tick();
         done = (owner == 0) && !mv[0] && !mv[1] && !merr;
      end
      quiet();
      check("drain_bound", {31'b0, done}, 32'd1);
   endtask

   initial begin
      int cnt;
      int cnt2;
      model_reset();
      quiet();
      d_ce_i = 1;
      @(negedge clk);
      #1;
      check("rst_bus_req", {31'b0, bus_req_o}, 32'd0);
      check("rst_bus_we", {31'b0, bus_we_o}, 32'd0);
      check("rst_bus_addr", bus_addr_o, 32'd0);
      check("rst_bus_sel", {28'b0, bus_sel_o}, 32'd0);
      check("rst_bus_data", bus_data_o, 32'd0);
      check("rst_bus_err", {31'b0, bus_err_o}, 32'd0);
      check("rst_d_data", d_data_o, 32'd0);
      check("rst_i_data", i_data_o, 32'd0);
      check("rst_d_stall", {31'b0, d_stallreq_o}, 32'd1);
      @(negedge clk);
      rst = 0;
      quiet();

      // Load, ack three cycles after request.
      d_ce_i = 1; d_addr_i = 32'h100; d_sel_i = 4'hf; bus_data_i = 32'hDEADBEEF;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         bus_ack_i = (k == 3);
         tick();
         if (o_dstall) cnt++;
         if (k == 3) check("load_req_on_ack_cycle", {31'b0, o_req}, 32'd1);
      end
      check("load_stall_cycles", cnt, 32'd4);
      check("load_data", o_ddata, 32'hDEADBEEF);
      check("load_req_dropped", {31'b0, o_req}, 32'd0);
      drain();
      $display("[TB] load done");

      // Contention: data first, then fetch.
      d_ce_i = 1; d_addr_i = 32'h300; d_sel_i = 4'hf; d_we_i = 0;
      i_ce_i = 1; i_addr_i = 32'h400;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) d_ce_i = 0;
         bus_ack_i = (k == 1 || k == 4);
         bus_data_i = (k == 1) ? 32'hA5A5A5A5 : 32'h12345678;
         tick();
         if (o_istall) cnt++;
         if (k == 1) check("cont_first_addr", o_addr, 32'h300);
         if (k == 2) check("cont_d_data", o_ddata, 32'hA5A5A5A5);
         if (k == 3) check("cont_second_addr", o_addr, 32'h400);
         if (k == 3) check("cont_second_sel", {28'b0, o_sel}, 32'hf);
      end
      check("cont_i_stall_cycles", cnt, 32'd5);
      check("cont_i_data", o_idata, 32'h12345678);
      drain();
      $display("[TB] contention done");

      // Result held while MEM is stalled.
      d_ce_i = 1; d_addr_i = 32'h140; d_hold_i = 1; bus_data_i = 32'hCAFEF00D;
      cnt = 0;
      for (int k = 0; k < 7; k++) begin
         bus_ack_i = (k == 1);
         d_hold_i = (k < 5);
         tick();
         if (k >= 2 && k <= 5) begin
            if (o_req) cnt++;
            check("hold_data_stable", o_ddata, 32'hCAFEF00D);
         end
      end
      check("hold_no_reissue", cnt, 32'd0);
      check("hold_vld_cleared", {31'b0, o_dstall}, 32'd1);
      drain();
      $display("[TB] hold done");

      // Store.
      d_ce_i = 1; d_we_i = 1; d_sel_i = 4'b0011; d_data_i = 32'h0000ABCD; d_addr_i = 32'h202;
      bus_data_i = 32'hFFFFFFFF;
      for (int k = 0; k < 3; k++) begin
         bus_ack_i = (k == 1);
         tick();
         if (k == 1) begin
            check("store_we", {31'b0, o_we}, 32'd1);
            check("store_sel", {28'b0, o_sel}, 32'h3);
            check("store_wdata", o_wdata, 32'h0000ABCD);
            check("store_addr", o_addr, 32'h202);
         end
      end
      check("store_d_data", o_ddata, 32'h0);
      check("store_stall_released", {31'b0, o_dstall}, 32'd0);
      drain();
      $display("[TB] store done");

      // Flush while a fetch is in flight.
      i_ce_i = 1; i_addr_i = 32'h500; bus_data_i = 32'h11111111;
      for (int k = 0; k < 6; k++) begin
         flush = (k == 1);
         bus_ack_i = (k == 3);
         tick();
         if (k == 4) begin
            check("flush_no_result", {31'b0, o_istall}, 32'd1);
            check("flush_req_dropped", {31'b0, o_req}, 32'd0);
         end
      end
      check("flush_refetch_req", {31'b0, o_req}, 32'd1);
      check("flush_refetch_addr", o_addr, 32'h500);
      drain();
      $display("[TB] flush done");

      // Watchdog: no ack ever.
      d_ce_i = 1; d_we_i = 0; d_sel_i = 4'hf; d_addr_i = 32'h600;
      cnt = 0; cnt2 = 0;
      for (int k = 0; k < 8; k++) begin
         if (k >= 6) d_ce_i = 0;
         tick();
         if (o_req) cnt++;
         if (o_err) cnt2++;
         if (k == 5) begin
            check("wdog_err", {31'b0, o_err}, 32'd1);
            check("wdog_stall_released", {31'b0, o_dstall}, 32'd0);
            check("wdog_data_zero", o_ddata, 32'h0);
         end
      end
      check("wdog_busy_cycles", cnt, 32'd4);
      check("wdog_err_pulses", cnt2, 32'd1);
      drain();
      $display("[TB] watchdog done");

      // Randomised traffic.
      for (int k = 0; k < 3000; k++) begin
         d_ce_i   = $urandom_range(0, 1);
         d_we_i   = $urandom_range(0, 1);
         d_addr_i = $urandom;
         d_sel_i  = 4'($urandom);
         d_data_i = $urandom;
         d_hold_i = ($urandom_range(0, 9) < 3);
         i_ce_i   = $urandom_range(0, 1);
         i_addr_i = $urandom & 32'hFFFF_FFFC;
         i_hold_i = ($urandom_range(0, 9) < 3);
         flush    = ($urandom_range(0, 19) == 0);
         bus_ack_i = (owner != 0) && ($urandom_range(0, 2) == 0);
         bus_data_i = $urandom;
         tick();
      end
      drain();
      $display("[TB] random done, %0d checks so far", tests);

      // Asynchronous reset in the middle of a transaction.
      d_ce_i = 1; d_addr_i = 32'h700;
      tick();
      check("prereset_req", {31'b0, bus_req_o}, 32'd1);
      rst = 1;
      #1;
      check("async_rst_req", {31'b0, bus_req_o}, 32'd0);
      check("async_rst_addr", bus_addr_o, 32'd0);
      check("async_rst_stall", {31'b0, d_stallreq_o}, 32'd1);
      model_reset();
      @(negedge clk);
      rst = 0;
      quiet();
      tick();
      tick();
      $display("[TB] reset done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one unified, variable-latency memory bus between two requesters:
  - the instruction-fetch port;
  - the data port driven by the MEM stage (load/store address, byte select, write data).
- Serialises accesses, holds pipeline stall requests until each access completes, and buffers the returned word until the pipeline consumes it.
- Sits between the IF/MEM stages and the external memory; its stall requests feed the pipeline control unit.

Parameters:
- TIMEOUT, 255: bus-ack watchdog limit in cycles; 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush (exception); discards buffered and in-flight results.
- i_ce_i  in  1  instruction fetch request.
- i_addr_i  in  32  fetch address, word aligned.
- i_hold_i  in  1  IF stage stalled this cycle; buffered result is not yet consumed.
- i_data_o  out  32  fetched instruction word.
- i_stallreq_o  out  1  fetch not yet complete.
- d_ce_i  in  1  data access request.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  32  data address (MEM stage already word-aligns LWL/LWR/SWL/SWR).
- d_sel_i  in  4  byte enables; bit 3 = bits 31:24.
- d_data_i  in  32  store data.
- d_hold_i  in  1  MEM stage stalled this cycle.
- d_data_o  out  32  load data word.
- d_stallreq_o  out  1  data access not yet complete.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  32  bus address.
- bus_sel_o  out  4  bus byte enables.
- bus_data_o  out  32  bus write data.
- bus_data_i  in  32  bus read data, valid with ack.
- bus_ack_i  in  1  one-cycle completion strobe.
- bus_err_o  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset values: all bus_* outputs 0, i_data_o/d_data_o 0, valid flags 0, state IDLE, counter 0.
- Each port keeps a result-valid flag (vld) and a 32-bit result buffer.
- Stall requests are combinational: d_stallreq_o = d_ce_i & ~d_vld; i_stallreq_o = i_ce_i & ~i_vld.
- vld is cleared on the first cycle in which vld=1 and hold_i=0 (result consumed), so a held request is never re-issued.
- FSM states: IDLE, BUSY_D, BUSY_I.
  - IDLE → BUSY_D when d_ce_i & ~d_vld. Data has priority because it belongs to the older instruction.
  - Otherwise IDLE → BUSY_I when i_ce_i & ~i_vld.
  - On entry, bus_* outputs are registered from the winning port: instruction port uses we=0, sel=4'b1111.
- In BUSY the bus outputs are held constant until bus_ack_i.
  - On ack, bus_req_o drops at the same edge, the owner's vld is set, and bus_data_i is captured (loads and fetches only; stores leave the buffer at 0).
  - FSM returns to IDLE. A new request may be registered the cycle after the return to IDLE, never on the ack edge.
- Minimum access costs 2 stall cycles: request registered at edge 1, ack in cycle 1, vld set at edge 2.
- Watchdog counts cycles in BUSY. Reaching TIMEOUT without ack:
  - drop bus_req_o and return to IDLE;
  - set the owner's vld with buffer 0;
  - pulse bus_err_o for one cycle.
- flush:
  - clears both vld flags at the next edge.
  - If BUSY, sets a discard flag. The transaction still waits for ack (the bus cannot be aborted); on ack, vld is not set and the FSM returns to IDLE.
  - The discard flag clears on ack or timeout.
  - Requests presented during flush are ignored that cycle.
- Simultaneous ack and flush: discard wins.
- Simultaneous consume (hold_i=0) and a new request from the same port: vld clears, and the request is arbitrated next cycle.
- Reset mid-transaction: everything clears immediately; bus_req_o drops asynchronously.

Decomposition:
- defines.v additions:
  - state encodings `ArbIdle, `ArbBusyD, `ArbBusyI;
  - `ChipEnable/`writeEnable reused;
  - `RegBus for 32-bit widths.
- One sub-module, mem_arb_port: per-port vld flag and result buffer, capture/consume/flush logic. Instantiated twice.

Test Plan:
- Load only: d_ce=1, we=0, addr=0x100, sel=1111; ack 3 cycles after req with data 0xDEADBEEF → d_stallreq high 4 cycles, d_data_o=0xDEADBEEF, bus_req de-asserts on the ack edge.
- Contention: i_ce and d_ce both asserted in IDLE → data access goes first (bus_addr=d_addr), then fetch starts the cycle after the data ack; i_stallreq stays high throughout.
- Hold: data completes while d_hold_i=1 for 3 cycles → no second bus_req, d_data_o held stable; vld clears when hold drops.
- Store: we=1, sel=0011, data=0x0000ABCD, addr=0x202 → bus_we=1, bus_sel=0011, bus_data=0x0000ABCD, d_data_o=0.
- Flush in flight: flush while BUSY_I, ack 2 cycles later → i_vld stays 0, no result; a new fetch is issued after the ack.
- Watchdog: TIMEOUT=4, ack never arrives → bus_req drops after 4 BUSY cycles, bus_err_o pulses once, stall released with data 0.
